// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability-count debouncer and
// hold-to-auto-repeat, producing registered one-cycle strobes for a downstream start input.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_level,
  output logic o_pressed,
  output logic o_released,
  output logic o_repeat,
  output logic o_start
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  // db_cnt holds the number of agreeing samples already seen, so the sample
  // that brings the run to DEBOUNCE_CYCLES is the one that is accepted.
  localparam logic [DB_W-1:0] DB_LAST        = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);
  localparam logic [RP_W-1:0] RP_SAT         = '1;
  localparam bit              DB_ONE         = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [2:0] {
    S_REL   = 3'd0,
    S_PWAIT = 3'd1,
    S_HELD  = 3'd2,
    S_RPT   = 3'd3,
    S_RWAIT = 3'd4
  } state_t;

  state_t            state;
  logic              sync1;
  logic              sync2;
  logic              key_s;
  logic [DB_W-1:0]   db_cnt;
  logic [RP_W-1:0]   rp_cnt;

  assign key_s = ~sync2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      state      <= S_REL;
      db_cnt     <= '0;
      rp_cnt     <= '0;
      o_level    <= 1'b0;
      o_pressed  <= 1'b0;
      o_released <= 1'b0;
      o_repeat   <= 1'b0;
      o_start    <= 1'b0;
    end else begin
      sync1      <= i_key_n;
      sync2      <= sync1;
      o_pressed  <= 1'b0;
      o_released <= 1'b0;
      o_repeat   <= 1'b0;
      o_start    <= 1'b0;

      case (state)
        S_REL: begin
          if (key_s) begin
            if (DB_ONE) begin
              state     <= S_HELD;
              db_cnt    <= '0;
              rp_cnt    <= '0;
              o_level   <= 1'b1;
              o_pressed <= 1'b1;
              o_start   <= 1'b1;
            end else begin
              state  <= S_PWAIT;
              db_cnt <= DB_W'(1);
            end
          end
        end

        S_PWAIT: begin
          if (!key_s) begin
            state  <= S_REL;
            db_cnt <= '0;
          end else if (db_cnt >= DB_LAST) begin
            state     <= S_HELD;
            db_cnt    <= '0;
            rp_cnt    <= '0;
            o_level   <= 1'b1;
            o_pressed <= 1'b1;
            o_start   <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        S_HELD, S_RPT: begin
          if (!key_s) begin
            // A release sample always beats a repeat that happens to be due.
            rp_cnt <= '0;
            if (DB_ONE) begin
              state      <= S_REL;
              db_cnt     <= '0;
              o_level    <= 1'b0;
              o_released <= 1'b1;
            end else begin
              state  <= S_RWAIT;
              db_cnt <= DB_W'(1);
            end
          end else if (state == S_HELD) begin
            if (REPEAT_EN && (rp_cnt == RP_DELAY_LAST)) begin
              state    <= S_RPT;
              rp_cnt   <= '0;
              o_repeat <= 1'b1;
              o_start  <= 1'b1;
            end else if (rp_cnt != RP_SAT) begin
              rp_cnt <= rp_cnt + 1'b1;
            end
          end else begin
            if (rp_cnt == RP_PERIOD_LAST) begin
              rp_cnt   <= '0;
              o_repeat <= 1'b1;
              o_start  <= 1'b1;
            end else begin
              rp_cnt <= rp_cnt + 1'b1;
            end
          end
        end

        S_RWAIT: begin
          if (key_s) begin
            // Bounce back to pressed: the repeat delay starts over in full.
            state  <= S_HELD;
            db_cnt <= '0;
            rp_cnt <= '0;
          end else if (db_cnt >= DB_LAST) begin
            state      <= S_REL;
            db_cnt     <= '0;
            o_level    <= 1'b0;
            o_released <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        default: begin
          state   <= S_REL;
          db_cnt  <= '0;
          rp_cnt  <= '0;
          o_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: vector table, directed multi-cycle sequences and random
// key activity checked every cycle against a run-length/age reference model.
module tb_key_debounce;

  localparam int N = 4;
  localparam int D = 10;
  localparam int P = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_n;
  logic [1:0] lvl, prs, rls, rpt, st;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  key_debounce #(.DEBOUNCE_CYCLES(N), .REPEAT_EN(1'b1), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
    .i_clk(clk), .i_rst(rst), .i_key_n(key_n),
    .o_level(lvl[0]), .o_pressed(prs[0]), .o_released(rls[0]), .o_repeat(rpt[0]), .o_start(st[0])
  );

  key_debounce #(.DEBOUNCE_CYCLES(N), .REPEAT_EN(1'b0), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut_nr (
    .i_clk(clk), .i_rst(rst), .i_key_n(key_n),
    .o_level(lvl[1]), .o_pressed(prs[1]), .o_released(rls[1]), .o_repeat(rpt[1]), .o_start(st[1])
  );

  // Reference model: key seen 2 samples late; level flips after N consecutive
  // disagreeing samples; repeats fall at hold ages D, D+P, D+2P, ...
  bit       m_s1[2]  = '{1'b1, 1'b1};
  bit       m_s2[2]  = '{1'b1, 1'b1};
  bit       m_lvl[2] = '{1'b0, 1'b0};
  int       m_dis[2] = '{0, 0};
  int       m_age[2] = '{0, 0};
  logic [4:0] m_out[2];

  typedef struct {
    logic       k;
    logic       r;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [4:0] dut_out(input int i);
    return {lvl[i], prs[i], rls[i], rpt[i], st[i]};
  endfunction

  task automatic model_step(input int i, input bit k, input bit r);
    bit ks, pr, rl, rp;
    if (r) begin
      m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_lvl[i] = 1'b0;
      m_dis[i] = 0; m_age[i] = 0; m_out[i] = '0;
      return;
    end
    ks = !m_s2[i];
    m_s2[i] = m_s1[i];
    m_s1[i] = k;
    pr = 1'b0; rl = 1'b0; rp = 1'b0;
    if (ks != m_lvl[i]) begin
      m_dis[i]++;
      if (m_dis[i] == N) begin
        m_lvl[i] = ks; m_dis[i] = 0; m_age[i] = 0;
        pr = ks; rl = !ks;
      end
    end else begin
      if (m_lvl[i]) begin
        if (m_dis[i] > 0) m_age[i] = 0;
        else begin
          m_age[i]++;
          if (i == 0 && m_age[i] >= D && ((m_age[i] - D) % P) == 0) rp = 1'b1;
        end
      end
      m_dis[i] = 0;
    end
    m_out[i] = {m_lvl[i], pr, rl, rp, pr | rp};
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input bit k, input bit r);
    key_n = k;
    rst   = r;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      model_step(i, k, r);
      check($sformatf("model_dut%0d", i), 32'(dut_out(i)), 32'(m_out[i]));
    end
  endtask

  task automatic add(input bit k, input bit r, input int n, input logic [4:0] e);
    for (int j = 0; j < n; j++) vecs.push_back('{k, r, e});
  endtask

  initial begin
    int np, nr, nrl, rel_at;
    bit exp_r;
    key_n = 1'b1;
    rst   = 1'b1;

    // {level, pressed, released, repeat, start}
    add(1, 1, 2, 5'b00000);
    add(1, 0, 5, 5'b00000);
    add(0, 0, 5, 5'b00000);
    add(0, 0, 1, 5'b11001);
    add(0, 0, 2, 5'b10000);
    add(1, 0, 5, 5'b10000);
    add(1, 0, 1, 5'b00100);
    add(1, 0, 1, 5'b00000);
    add(0, 0, 3, 5'b00000);
    add(1, 0, 8, 5'b00000);
    for (int j = 0; j < vecs.size(); j++) begin
      tick(vecs[j].k, vecs[j].r);
      check($sformatf("vec%0d", j), 32'(dut_out(0)), 32'(vecs[j].exp));
      $display("vec %0d: key_n=%0b rst=%0b out=%b", j, vecs[j].k, vecs[j].r, dut_out(0));
    end

    // Hold: press after 6 edges, repeats at +10, +13, +16.
    for (int e = 1; e <= 6; e++) begin
      tick(0, 0);
      check("t3_press", 32'({prs[0], st[0]}), (e == 6) ? 32'd3 : 32'd0);
    end
    for (int k = 1; k <= 17; k++) begin
      tick(0, 0);
      exp_r = (k == 10 || k == 13 || k == 16);
      check("t3_repeat", 32'({rpt[0], st[0]}), 32'({exp_r, exp_r}));
    end
    $display("hold sequence: repeats checked at press+10/13/16");

    // 2-cycle release bounce: one due repeat, then delay restarts at edge 5.
    for (int e = 1; e <= 16; e++) begin
      tick((e <= 2) ? 1'b1 : 1'b0, 0);
      exp_r = (e == 2 || e == 15);
      check("t4_bounce", 32'({lvl[0], rls[0], rpt[0]}), 32'({1'b1, 1'b0, exp_r}));
    end
    for (int e = 1; e <= 8; e++) begin
      tick(1, 0);
      check("t4_release", 32'({lvl[0], rls[0]}), 32'({(e < 6), (e == 6)}));
    end
    $display("bounce sequence: restart and clean release checked");

    // Repeat disabled instance: one press, no repeat, one release at edge 6.
    tick(1, 1);
    for (int e = 0; e < 3; e++) tick(1, 0);
    np = 0; nr = 0; nrl = 0; rel_at = -1;
    for (int e = 1; e <= 40; e++) begin
      tick(0, 0);
      np += int'(prs[1]);
      nr += int'(rpt[1]);
    end
    for (int e = 1; e <= 10; e++) begin
      tick(1, 0);
      nr += int'(rpt[1]);
      if (rls[1]) begin
        nrl++;
        rel_at = e;
      end
    end
    check("t5_presses", np, 1);
    check("t5_repeats", nr, 0);
    check("t5_releases", nrl, 1);
    check("t5_release_edge", rel_at, 6);
    $display("no-repeat sequence: presses=%0d repeats=%0d releases=%0d at edge %0d", np, nr, nrl, rel_at);

    // Reset while auto-repeating with the key still held.
    tick(1, 1);
    for (int e = 0; e < 3; e++) tick(1, 0);
    for (int e = 0; e < 20; e++) tick(0, 0);
    tick(0, 1);
    check("t6_reset_outs", 32'({dut_out(1), dut_out(0)}), 32'd0);
    for (int e = 1; e <= 8; e++) begin
      tick(0, 0);
      check("t6_fresh_press", 32'({lvl[0], prs[0]}), 32'({(e >= 6), (e == 6)}));
    end
    $display("reset sequence: outputs cleared, fresh press checked");

    // Random key activity with occasional resets.
    for (int run = 0; run < 150; run++) begin
      bit k, r;
      int len;
      k   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 30));
      r   = ($urandom_range(0, 99) == 0);
      for (int t = 0; t < len; t++) tick(k, r && (t == 0));
      $display("random run %0d: key_n=%0b len=%0d rst=%0b level=%0b", run, k, len, r, lvl[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
